// File: rtl/clock_divider.sv
// clock_divider: programmable integer divider producing a registered,
// glitch-free divided clock plus a one-cycle tick on the last clk cycle
// of every divided period. Divisor changes use a load/ack handshake and
// take effect only on period boundaries; stopping always finishes the
// period in progress.
//
// Ports:
//   clk, rst_n     - system clock, asynchronous active-low reset
//   run            - 1 = run, 0 = stop at the end of the current period
//   div_in/div_load- requested divisor and its one-cycle load strobe
//   div_busy       - a captured divisor is waiting to be committed
//   div_ack        - one-cycle pulse when the pending divisor commits
//   div_err        - one-cycle pulse when a load of 0 is rejected
//   div_active     - divisor currently in effect
//   clk_out, tick  - divided clock and end-of-period pulse (both flops)
module clock_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_ack,
  output logic             div_err,
  output logic [WIDTH-1:0] div_active,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] act_nxt, half_nxt;
  logic             wrap, commit, accept, reject;
  logic             clk_out_nxt, tick_nxt;

  // State register. Outputs are flops fed from next-state decode so they
  // only ever move on a clk rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= '0;
      div_active <= DEF;
      div_busy   <= 1'b0;
      div_ack    <= 1'b0;
      div_err    <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      div_active <= act_nxt;
      div_ack    <= commit;
      div_err    <= reject;
      clk_out    <= clk_out_nxt;
      tick       <= tick_nxt;
      if (accept)      pending <= div_in;
      if (accept)      div_busy <= 1'b1;
      else if (commit) div_busy <= 1'b0;
    end
  end

  // Next-state / counter / handshake decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wrap      = (state != IDLE) && (cnt == div_active - ONE);
    // Loads are only looked at while nothing is pending; a load that
    // lands on a commit edge still sees div_busy=1 and is dropped.
    accept    = div_load && !div_busy && (div_in != '0);
    reject    = div_load && !div_busy && (div_in == '0);
    // IDLE commits right away; otherwise wait for the period boundary.
    commit    = div_busy && ((state == IDLE) || wrap);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (run) state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = wrap ? '0 : cnt + ONE;
        // run dropping exactly on the last cycle ends the period now.
        if (!run) state_nxt = wrap ? IDLE : DRAIN;
      end
      DRAIN: begin
        cnt_nxt = wrap ? '0 : cnt + ONE;
        if (run)       state_nxt = RUN;
        else if (wrap) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode on next-state values. The divisor committed on a wrap
  // already governs the period starting at that edge.
  always_comb begin
    act_nxt     = commit ? pending : div_active;
    half_nxt    = act_nxt >> 1;
    clk_out_nxt = (state_nxt != IDLE) && (cnt_nxt >= act_nxt - half_nxt);
    tick_nxt    = (state_nxt != IDLE) && (cnt_nxt == act_nxt - ONE);
  end

endmodule
